// File: rtl/regfile_wb_ctrl.sv
// Register file write-back controller: post-reset zero-fill, ALU/LSU
// write-port arbitration with starvation guard, and busy-bit scoreboard.
module regfile_wb_ctrl #(
  parameter int STARVE_MAX = 4,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_vld,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_rdy,
  input  logic            lsu_vld,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_rdy,
  input  logic            iss_vld,
  input  logic [4:0]      iss_rd,
  output logic            iss_rdy,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            flush,
  output logic            rwr_en,
  output logic [4:0]      wr_r,
  output logic [XLEN-1:0] wr_d,
  output logic            init_done
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic {INIT, RUN} state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx;
  logic [3:0]  starve;
  logic [31:0] busy, busy_nxt;
  logic        alu_win, lsu_win;

  always_comb begin
    alu_win = 1'b0;
    lsu_win = 1'b0;
    if (init_done) begin
      alu_win = alu_vld & (~lsu_vld | (starve == SMAX));
      lsu_win = lsu_vld & ~alu_win;
    end
  end

  assign alu_rdy  = alu_win;
  assign lsu_rdy  = lsu_win;
  assign iss_rdy  = init_done & ~busy[iss_rd];
  assign rs1_busy = init_done & busy[chk_rs1];
  assign rs2_busy = init_done & busy[chk_rs2];

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (idx == 5'd31) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      idx       <= 5'd1;
      init_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == INIT) idx <= idx + 5'd1;
      if (state == RUN) init_done <= 1'b1;
    end
  end

  // INIT writes take the port unconditionally; rdy is low then anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rwr_en <= 1'b0;
      wr_r   <= '0;
      wr_d   <= '0;
    end else begin
      unique case (1'b1)
        state == INIT: begin
          rwr_en <= 1'b1;
          wr_r   <= idx;
          wr_d   <= '0;
        end
        alu_win: begin
          rwr_en <= alu_rd != 5'd0;
          wr_r   <= alu_rd;
          wr_d   <= alu_data;
        end
        lsu_win: begin
          rwr_en <= lsu_rd != 5'd0;
          wr_r   <= lsu_rd;
          wr_d   <= lsu_data;
        end
        default: rwr_en <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (alu_vld & init_done & ~alu_win) begin
      if (starve != SMAX) starve <= starve + 4'd1;
    end else begin
      starve <= '0;
    end
  end

  // Priority: flush > set > clear.
  always_comb begin
    busy_nxt = busy;
    if (rwr_en) busy_nxt[wr_r] = 1'b0;
    if (iss_vld & iss_rdy) busy_nxt[iss_rd] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized bench for regfile_wb_ctrl against a cycle-count and
// bit-array reference model of the write-back rules.
module tb_regfile_wb_ctrl;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_vld = 0, lsu_vld = 0, iss_vld = 0, flush = 0;
  logic [4:0]  alu_rd = 0, lsu_rd = 0, iss_rd = 0;
  logic [4:0]  chk_rs1 = 0, chk_rs2 = 0;
  logic [31:0] alu_data = 0, lsu_data = 0;
  logic        alu_rdy, lsu_rdy, iss_rdy, rs1_busy, rs2_busy;
  logic        rwr_en, init_done;
  logic [4:0]  wr_r;
  logic [31:0] wr_d;

  regfile_wb_ctrl #(.STARVE_MAX(SM), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_vld(alu_vld), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_rdy(alu_rdy),
    .lsu_vld(lsu_vld), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_rdy(lsu_rdy),
    .iss_vld(iss_vld), .iss_rd(iss_rd), .iss_rdy(iss_rdy),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .flush(flush),
    .rwr_en(rwr_en), .wr_r(wr_r), .wr_d(wr_d),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  int          k;
  bit          bsy [32];
  int          starve;
  bit          e_en;
  logic [4:0]  e_r;
  logic [31:0] e_d;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h (k=%0d t=%0t)",
               tag, got, exp, k, $time);
    end
  endtask

  task automatic cycle(input bit av, input logic [4:0] ard,
                       input logic [31:0] ad,
                       input bit lv, input logic [4:0] lrd,
                       input logic [31:0] ld,
                       input bit iv, input logic [4:0] ird,
                       input logic [4:0] c1, input logic [4:0] c2,
                       input bit fl);
    bit done, aw, lw, ir;
    alu_vld = av; alu_rd = ard; alu_data = ad;
    lsu_vld = lv; lsu_rd = lrd; lsu_data = ld;
    iss_vld = iv; iss_rd = ird;
    chk_rs1 = c1; chk_rs2 = c2; flush = fl;
    #1;
    done = (k >= 32);
    aw = done && av && (!lv || starve == SM);
    lw = done && lv && !aw;
    ir = done && (ird == 0 || !bsy[ird]);
    check("init_done", init_done, done);
    check("alu_rdy", alu_rdy, aw);
    check("lsu_rdy", lsu_rdy, lw);
    check("iss_rdy", iss_rdy, ir);
    check("rs1_busy", rs1_busy, done && bsy[c1]);
    check("rs2_busy", rs2_busy, done && bsy[c2]);
    check("rwr_en", rwr_en, e_en);
    if (e_en) begin
      check("wr_r", wr_r, e_r);
      check("wr_d", wr_d, e_d);
    end
    if (fl) begin
      foreach (bsy[i]) bsy[i] = 0;
    end else begin
      if (e_en) bsy[e_r] = 0;
      if (iv && ir && ird != 0) bsy[ird] = 1;
    end
    if (k < 31) begin
      e_en = 1; e_r = 5'(k + 1); e_d = 0;
    end else if (aw) begin
      e_en = (ard != 0); e_r = ard; e_d = ad;
    end else if (lw) begin
      e_en = (lrd != 0); e_r = lrd; e_d = ld;
    end else begin
      e_en = 0;
    end
    if (done && av && !aw) starve = (starve < SM) ? starve + 1 : SM;
    else starve = 0;
    k++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 7, 9, 0);
  endtask

  task automatic do_reset(input logic [4:0] c1);
    #2;
    chk_rs1 = c1;
    rst_n = 1'b0;
    #1;
    check("rst_rwr_en", rwr_en, 0);
    check("rst_wr_r", wr_r, 0);
    check("rst_wr_d", wr_d, 0);
    check("rst_init_done", init_done, 0);
    check("rst_rs1_busy", rs1_busy, 0);
    check("rst_alu_rdy", alu_rdy, 0);
    k = 0; starve = 0; e_en = 0; e_r = 0; e_d = 0;
    foreach (bsy[i]) bsy[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] rnd_rd();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic rnd_cycle();
    cycle($urandom_range(0, 2) != 0, rnd_rd(), $urandom,
          $urandom_range(0, 2) != 0, rnd_rd(), $urandom,
          $urandom_range(0, 1) != 0, rnd_rd(),
          rnd_rd(), rnd_rd(), $urandom_range(0, 15) == 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset(0);
    idle(34);
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 12; i++)
      cycle(1, 3, $urandom, 1, 4, $urandom, 0, 0, 0, 0, 0);
    idle(2);
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0);
    cycle(0, 0, 0, 1, 7, 32'h1234, 0, 0, 7, 0, 0);
    idle(3);
    cycle(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0);
    idle(2);
    cycle(0, 0, 0, 1, 9, 32'h98, 0, 0, 9, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 1);
    idle(2);
    cycle(0, 0, 0, 1, 9, 32'h97, 0, 0, 9, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 1);
    idle(2);
    cycle(1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 2000; i++) rnd_cycle();
    cycle(0, 0, 0, 0, 0, 0, 1, 12, 12, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 13, 12, 13, 0);
    do_reset(12);
    idle(36);
    for (int i = 0; i < 400; i++) rnd_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
